// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
// The state encoding and the round-robin search are used by dm_arbiter and dm_rr_arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_RDATA = 2'd2
    } state_t;

    localparam int N_REQ_MAX = 4;
    localparam int IDX_W     = 2;

    // Returns {found, index}: first set bit of valid scanning ptr+1, ptr+2, ... modulo n.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ_MAX-1:0] valid,
                                               input logic [IDX_W-1:0]     ptr,
                                               input int                   n);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int i = 1; i <= N_REQ_MAX; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if ((i <= n) && !res[IDX_W] && valid[idx[IDX_W-1:0]]) begin
                res = {1'b1, idx[IDX_W-1:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_rr_arbiter.sv
// Combinational round-robin pick among masked requesters.
// Produces a one-hot grant plus the winning index; any=0 when nobody is eligible.
module dm_rr_arbiter
    import dm_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ_MAX-1:0] cand;
    logic [IDX_W:0]       pick;

    always_comb begin
        cand = '0;
        cand[N_REQ-1:0] = valid & mask;
        pick = rr_pick(cand, ptr, N_REQ);
        any  = pick[IDX_W];
        idx  = pick[IDX_W-1:0];
        grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = any && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port between N_REQ requesters.
// Optional DM_ARB_LOCK_EN adds i_req_lock so one owner can hold the port for RMW/AMO sequences.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    // Handshake: a requester holds i_req_valid and a stable payload until it sees its
    // o_req_ready bit; the transfer happens in that cycle. Dropping valid earlier loses it.
    input  logic [N_REQ-1:0]             i_req_valid,
    input  logic [N_REQ*ADDR_W-1:0]      i_req_addr,
    input  logic [N_REQ*DATA_W-1:0]      i_req_wd,
    input  logic [N_REQ*(DATA_W/8)-1:0]  i_req_wen,
    input  logic [N_REQ-1:0]             i_req_ren,
`ifdef DM_ARB_LOCK_EN
    input  logic [N_REQ-1:0]             i_req_lock,
`endif
    output logic [N_REQ-1:0]             o_req_ready,
    output logic [N_REQ-1:0]             o_req_rvalid,
    output logic [DATA_W-1:0]            o_req_rd,
    output logic [ADDR_W-1:0]            o_DM_addr,
    output logic [DATA_W-1:0]            o_DM_wd,
    output logic [(DATA_W/8)-1:0]        o_DM_wen,
    output logic                         o_DM_ren,
    input  logic [DATA_W-1:0]            i_DM_rd,
    output state_t                       o_dbg_state
);

    localparam int WEN_W = DATA_W / 8;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, owner, win_idx;
    logic [N_REQ-1:0]   grant, mask;
    logic               win_any, lock_held;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wd;
    logic [WEN_W-1:0]   sel_wen;
    logic [N_REQ_MAX-1:0] ren_ext;

    dm_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .valid (i_req_valid),
        .mask  (mask),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

`ifdef DM_ARB_LOCK_EN
    logic                 lock_q;
    logic [N_REQ_MAX-1:0] lock_ext;

    always_comb begin
        lock_ext = '0;
        lock_ext[N_REQ-1:0] = i_req_lock;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = !lock_q || (owner == IDX_W'(i));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_q <= 1'b0;
        end else if (state == S_IDLE && win_any) begin
            lock_q <= lock_ext[win_idx];
        end
    end

    assign lock_held = lock_q;
`else
    assign mask      = '1;
    assign lock_held = 1'b0;
`endif

    always_comb begin
        sel_addr = i_req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        sel_wd   = i_req_wd[int'(win_idx)*DATA_W +: DATA_W];
        sel_wen  = i_req_wen[int'(win_idx)*WEN_W +: WEN_W];
        ren_ext  = '0;
        ren_ext[N_REQ-1:0] = i_req_ren;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_any) state_nxt = S_CMD;
            S_CMD:   state_nxt = o_DM_ren ? S_RDATA : S_IDLE;
            S_RDATA: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state == S_IDLE && !i_rst) ? grant : '0;
        o_dbg_state = state;
    end

    // A write with ren set is treated as a plain write; the read is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_DM_addr <= '0;
            o_DM_wd   <= '0;
            o_DM_wen  <= '0;
            o_DM_ren  <= 1'b0;
            owner     <= '0;
            ptr       <= IDX_W'(N_REQ - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_any) begin
                        o_DM_addr <= sel_addr;
                        o_DM_wd   <= sel_wd;
                        o_DM_wen  <= sel_wen;
                        o_DM_ren  <= ren_ext[win_idx] && (sel_wen == '0);
                        owner     <= win_idx;
                        if (!lock_held) ptr <= win_idx;
                    end else begin
                        o_DM_addr <= '0;
                        o_DM_wd   <= '0;
                        o_DM_wen  <= '0;
                        o_DM_ren  <= 1'b0;
                    end
                end
                S_CMD: begin
                    o_DM_wen <= '0;
                    o_DM_ren <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_req_rd     <= '0;
            o_req_rvalid <= '0;
        end else begin
            if (state == S_RDATA) o_req_rd <= i_DM_rd;
            for (int i = 0; i < N_REQ; i++) begin
                o_req_rvalid[i] <= (state == S_RDATA) && (owner == IDX_W'(i));
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: transaction-level reference model feeds expected queues,
// a negedge monitor pops and compares whenever the DUT shows a grant, command or rvalid.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WW = DW / 8;

    logic            clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wd = '0;
    logic [N*WW-1:0] req_wen = '0;
    logic [N-1:0]    req_ren = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N-1:0]    req_ready, req_rvalid;
    logic [DW-1:0]   req_rd;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wd;
    logic [WW-1:0]   dm_wen;
    logic            dm_ren;
    logic [DW-1:0]   dm_rd = '0;
    state_t          dbg_state;

    always #5 clk = ~clk;

    dm_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_req_valid  (req_valid),
        .i_req_addr   (req_addr),
        .i_req_wd     (req_wd),
        .i_req_wen    (req_wen),
        .i_req_ren    (req_ren),
`ifdef DM_ARB_LOCK_EN
        .i_req_lock   (req_lock),
`endif
        .o_req_ready  (req_ready),
        .o_req_rvalid (req_rvalid),
        .o_req_rd     (req_rd),
        .o_DM_addr    (dm_addr),
        .o_DM_wd      (dm_wd),
        .o_DM_wen     (dm_wen),
        .o_DM_ren     (dm_ren),
        .i_DM_rd      (dm_rd),
        .o_dbg_state  (dbg_state)
    );

    // Data memory: byte-enable write, one-cycle synchronous read, 16 words.
    logic [DW-1:0] env_mem [16];
    initial for (int i = 0; i < 16; i++) env_mem[i] = '0;
    always @(posedge clk) begin
        for (int b = 0; b < WW; b++) begin
            if (dm_wen[b]) env_mem[dm_addr[5:2]][8*b +: 8] <= dm_wd[8*b +: 8];
        end
        if (dm_ren) dm_rd <= env_mem[dm_addr[5:2]];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Requester-side stimulus state
    bit          vld [N];
    logic [31:0] r_addr [N];
    logic [31:0] r_wd [N];
    logic [3:0]  r_wen [N];
    bit          r_ren [N];
    bit          r_lock [N];
    bit          rst_drv = 1'b1;
    bit          rand_on = 1'b0;

    // Reference model
    int          next_free = 0;
    int          last = N - 1;
    int          lock_own = -1;
    logic [31:0] ref_mem [16];

    typedef struct { int cyc; int idx; } g_t;
    typedef struct { int cyc; logic [31:0] addr; logic [31:0] wd; logic [3:0] wen; logic ren; } c_t;
    typedef struct { int cyc; int idx; logic [31:0] data; } r_t;
    g_t grant_q[$];
    c_t cmd_q[$];
    r_t rd_q[$];

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] w, input bit rd, input bit lk);
        r_addr[r] = a; r_wd[r] = d; r_wen[r] = w; r_ren[r] = rd; r_lock[r] = lk; vld[r] = 1'b1;
    endtask

    task automatic new_rand_req(input int r);
        logic [3:0] w;
        bit         lk;
        case ($urandom_range(0, 4))
            0:       w = 4'h0;
            1:       w = 4'hF;
            2:       w = 4'h3;
            3:       w = 4'hC;
            default: w = 4'($urandom_range(0, 15));
        endcase
        lk = 1'b0;
`ifdef DM_ARB_LOCK_EN
        lk = ($urandom_range(0, 7) == 0);
`endif
        set_req(r, 32'($urandom_range(0, 15)) << 2, $urandom, w, 1'($urandom_range(0, 1)), lk);
    endtask

    // One memory transaction per accept; a write occupies 2 cycles, a read 3, result 3 cycles later.
    task automatic model();
        int  w;
        bit  is_rd;
        int  wi;
        if (rst_drv) begin
            for (int i = rd_q.size() - 1; i >= 0; i--) if (rd_q[i].cyc > cyc) rd_q.delete(i);
            for (int i = cmd_q.size() - 1; i >= 0; i--) if (cmd_q[i].cyc > cyc) cmd_q.delete(i);
            last = N - 1;
            lock_own = -1;
            next_free = cyc + 1;
            return;
        end
        if (cyc < next_free) return;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (w < 0 && vld[j] && (lock_own < 0 || lock_own == j)) w = j;
        end
        if (w < 0) return;
        grant_q.push_back('{cyc, w});
        is_rd = 1'b0;
        wi = int'(r_addr[w][5:2]);
        if (r_wen[w] != 4'h0) begin
            for (int b = 0; b < 4; b++) if (r_wen[w][b]) ref_mem[wi][8*b +: 8] = r_wd[w][8*b +: 8];
            cmd_q.push_back('{cyc + 1, r_addr[w], r_wd[w], r_wen[w], 1'b0});
        end else if (r_ren[w]) begin
            cmd_q.push_back('{cyc + 1, r_addr[w], r_wd[w], 4'h0, 1'b1});
            rd_q.push_back('{cyc + 3, w, ref_mem[wi]});
            is_rd = 1'b1;
        end
        next_free = cyc + (is_rd ? 3 : 2);
        if (lock_own < 0) last = w;
        lock_own = r_lock[w] ? w : -1;
        vld[w] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_on) begin
            for (int r = 0; r < N; r++) begin
                if (!vld[r]) begin
                    if ($urandom_range(0, 2) == 0) new_rand_req(r);
                end else if ($urandom_range(0, 19) == 0) begin
                    vld[r] = 1'b0;
                end
            end
        end
        for (int r = 0; r < N; r++) begin
            req_valid[r]           = vld[r];
            req_addr[r*AW +: AW]   = r_addr[r];
            req_wd[r*DW +: DW]     = r_wd[r];
            req_wen[r*WW +: WW]    = r_wen[r];
            req_ren[r]             = r_ren[r];
            req_lock[r]            = r_lock[r];
        end
        i_rst = rst_drv;
        model();
    endtask

    task automatic wait_done(input int r);
        for (int k = 0; k < 50 && vld[r]; k++) step();
        chk("accept_timeout", !vld[r], 64'(vld[r]), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Monitor: pops expectations whenever the DUT presents an output; overdue entries are misses.
    always @(negedge clk) begin
        g_t g;
        c_t c;
        r_t r;
        while (grant_q.size() > 0 && grant_q[0].cyc < cyc) begin
            g = grant_q.pop_front();
            chk("grant_missing", 1'b0, 64'd0, 64'(g.idx));
        end
        while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
            c = cmd_q.pop_front();
            chk("cmd_missing", 1'b0, 64'd0, 64'(c.addr));
        end
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            r = rd_q.pop_front();
            chk("rvalid_missing", 1'b0, 64'd0, 64'(r.data));
        end
        if (req_ready != '0) begin
            if (grant_q.size() == 0) begin
                chk("grant_unexpected", 1'b0, 64'(req_ready), 64'd0);
            end else begin
                g = grant_q.pop_front();
                chk("grant", g.cyc == cyc && req_ready == onehot(g.idx), 64'(req_ready), 64'(onehot(g.idx)));
            end
        end
        if (dm_wen != '0 || dm_ren) begin
            if (cmd_q.size() == 0) begin
                chk("cmd_unexpected", 1'b0, {dm_addr, 27'd0, dm_wen, dm_ren}, 64'd0);
            end else begin
                c = cmd_q.pop_front();
                chk("cmd_cycle", c.cyc == cyc, 64'(cyc), 64'(c.cyc));
                chk("cmd_addr", dm_addr == c.addr, 64'(dm_addr), 64'(c.addr));
                chk("cmd_wd", dm_wd == c.wd, 64'(dm_wd), 64'(c.wd));
                chk("cmd_wen_ren", {dm_wen, dm_ren} == {c.wen, c.ren}, 64'({dm_wen, dm_ren}), 64'({c.wen, c.ren}));
            end
        end
        if (req_rvalid != '0) begin
            if (rd_q.size() == 0) begin
                chk("rvalid_unexpected", 1'b0, 64'(req_rvalid), 64'd0);
            end else begin
                r = rd_q.pop_front();
                chk("rvalid", r.cyc == cyc && req_rvalid == onehot(r.idx), 64'(req_rvalid), 64'(onehot(r.idx)));
                chk("rdata", req_rd == r.data, 64'(req_rd), 64'(r.data));
            end
        end
    end

    initial begin
        int c0, c1;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        for (int r = 0; r < N; r++) set_req(r, 32'd0, 32'd0, 4'h0, 1'b0, 1'b0);
        for (int r = 0; r < N; r++) vld[r] = 1'b0;

        // Reset with a request pending: nothing may be accepted or issued
        set_req(0, 32'h3C, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
        rst_drv = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_ready", req_ready == '0, 64'(req_ready), 64'd0);
        chk("rst_rvalid", req_rvalid == '0, 64'(req_rvalid), 64'd0);
        chk("rst_rd", req_rd == '0, 64'(req_rd), 64'd0);
        chk("rst_dm_addr", dm_addr == '0, 64'(dm_addr), 64'd0);
        chk("rst_dm_wd", dm_wd == '0, 64'(dm_wd), 64'd0);
        chk("rst_dm_wen_ren", {dm_wen, dm_ren} == '0, 64'({dm_wen, dm_ren}), 64'd0);
        vld[0] = 1'b0;
        rst_drv = 1'b0;

        // Directed write then read-back from another requester
        set_req(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
        wait_done(0);
        idle(3);
        set_req(1, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        wait_done(1);
        idle(4);

        // Both requesters continuously valid, six writes each
        c0 = 0; c1 = 0;
        for (int k = 0; k < 60; k++) begin
            if (!vld[0] && c0 < 6) begin set_req(0, 32'($urandom_range(0, 15)) << 2, $urandom, 4'hF, 1'b0, 1'b0); c0++; end
            if (!vld[1] && c1 < 6) begin set_req(1, 32'($urandom_range(0, 15)) << 2, $urandom, 4'hF, 1'b0, 1'b0); c1++; end
            step();
            if (c0 == 6 && c1 == 6 && !vld[0] && !vld[1]) break;
        end
        chk("fair_writes_done", !vld[0] && !vld[1], 64'({vld[0], vld[1]}), 64'd0);
        idle(3);

        // Write with ren set, then a NOP
        set_req(0, 32'h08, 32'hA5A5_5A5A, 4'h3, 1'b1, 1'b0);
        wait_done(0);
        set_req(0, 32'h0C, 32'h0, 4'h0, 1'b0, 1'b0);
        wait_done(0);
        idle(4);

        // Reset during RDATA abandons the read; req0 wins first afterwards
        set_req(1, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        wait_done(1);
        step();
        set_req(0, 32'h20, 32'h0000_1111, 4'hF, 1'b0, 1'b0);
        set_req(1, 32'h24, 32'h0000_2222, 4'hF, 1'b0, 1'b0);
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        step();
        @(negedge clk);
        chk("post_rst_rvalid", req_rvalid == '0, 64'(req_rvalid), 64'd0);
        chk("post_rst_dm", {dm_addr, dm_wen, dm_ren} == '0, 64'({dm_wen, dm_ren}), 64'd0);
        chk("post_rst_grant_req0", req_ready == onehot(0), 64'(req_ready), 64'(onehot(0)));
        wait_done(1);
        idle(3);

`ifdef DM_ARB_LOCK_EN
        // Locked read by req1 keeps req0 out until req1's unlocked write is accepted
        set_req(1, 32'h30, 32'h0, 4'h0, 1'b1, 1'b1);
        wait_done(1);
        set_req(0, 32'h34, 32'h0000_AAAA, 4'hF, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("lock_masks_req0", req_ready[0] == 1'b0, 64'(req_ready), 64'd0);
        end
        set_req(1, 32'h30, 32'h0000_5555, 4'hF, 1'b0, 1'b0);
        wait_done(1);
        wait_done(0);
        idle(3);
`endif

        // Randomized traffic with occasional resets
        rand_on = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            rst_drv = (k % 700 == 350);
            step();
        end
        rand_on = 1'b0;
        rst_drv = 1'b0;
        for (int r = 0; r < N; r++) vld[r] = 1'b0;
        idle(8);
        chk("grant_q_drained", grant_q.size() == 0, 64'(grant_q.size()), 64'd0);
        chk("cmd_q_drained", cmd_q.size() == 0, 64'(cmd_q.size()), 64'd0);
        chk("rd_q_drained", rd_q.size() == 0, 64'(rd_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
